// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency measurement path.
package freq_meas_pkg;

    localparam int unsigned CNT_WIDTH_DEF   = 24;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMING   = 2'd1,
        ST_COUNTING = 2'd2
    } meas_state_e;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous level with a registered
// one-cycle rising-edge pulse.
module sync_rise_detect
    import freq_meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse
);

    // Fewer than two stages would leave metastability unresolved.
    localparam int unsigned STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign level_out  = r_sync[STAGES-1];
    assign rise_pulse = r_rise;

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Counts ring-oscillator rising edges over each full gate period and hands the
// saturating count to the readout stage through a valid/ready handshake.
module ring_osc_freq_counter
    import freq_meas_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 osc_in,
    input  logic                 gate_in,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 saturated,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    meas_state_e          r_state;
    meas_state_e          w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_win_sat;
    logic                 w_win_sat_nxt;
    logic [CNT_WIDTH-1:0] r_result;
    logic [CNT_WIDTH-1:0] w_result_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_sat;
    logic                 w_sat_nxt;
    logic                 r_ovr;
    logic                 w_ovr_nxt;

    logic                 w_osc_rise;
    logic                 w_gate_rise;
    logic                 w_osc_level;
    logic                 w_gate_level;
    logic                 w_unused_levels;
    logic                 w_xfer;
    logic                 w_at_max;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [CNT_WIDTH-1:0] w_cnt_start;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_osc_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (osc_in),
        .level_out  (w_osc_level),
        .rise_pulse (w_osc_rise)
    );

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (gate_in),
        .level_out  (w_gate_level),
        .rise_pulse (w_gate_rise)
    );

    // Only the edge pulses drive the measurement; levels are not needed here.
    assign w_unused_levels = w_osc_level | w_gate_level;

    assign w_xfer      = r_valid & result_ready;
    assign w_at_max    = (r_cnt == CNT_MAX);
    assign w_cnt_inc   = w_at_max ? r_cnt : r_cnt + CNT_WIDTH'(1);
    // A window opens with the coincident osc edge already counted.
    assign w_cnt_start = w_osc_rise ? CNT_WIDTH'(1) : '0;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_win_sat <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_win_sat <= w_win_sat_nxt;
            r_result  <= w_result_nxt;
            r_valid   <= w_valid_nxt;
            r_sat     <= w_sat_nxt;
            r_ovr     <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_win_sat_nxt = r_win_sat;
        w_result_nxt  = r_result;
        w_valid_nxt   = r_valid;
        w_sat_nxt     = r_sat;
        w_ovr_nxt     = r_ovr;

        if (w_xfer) begin
            w_valid_nxt = 1'b0;
            w_ovr_nxt   = 1'b0;
        end

        if (!enable) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_win_sat_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt   = ST_ARMING;
                    w_cnt_nxt     = '0;
                    w_win_sat_nxt = 1'b0;
                end
                ST_ARMING: begin
                    if (w_gate_rise) begin
                        w_state_nxt   = ST_COUNTING;
                        w_cnt_nxt     = w_cnt_start;
                        w_win_sat_nxt = 1'b0;
                    end
                end
                ST_COUNTING: begin
                    if (w_gate_rise) begin
                        w_result_nxt  = w_osc_rise ? w_cnt_inc : r_cnt;
                        w_sat_nxt     = r_win_sat | (w_osc_rise & w_at_max);
                        w_valid_nxt   = 1'b1;
                        // Overwrite of an untaken result is flagged; a coincident transfer keeps overrun as is.
                        w_ovr_nxt     = r_ovr | (r_valid & ~result_ready);
                        w_cnt_nxt     = w_cnt_start;
                        w_win_sat_nxt = 1'b0;
                    end else if (w_osc_rise) begin
                        w_cnt_nxt     = w_cnt_inc;
                        w_win_sat_nxt = r_win_sat | w_at_max;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign saturated    = r_sat;
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Bench for ring_osc_freq_counter: directed window table, hand-written
// handshake/control sequences and randomized windows against an edge-count model.
module tb_ring_osc_freq_counter;

    localparam int unsigned CW    = 8;
    localparam int          CMAX  = 255;

    typedef struct {
        int   len;
        int   high;
        int   op;
        int   ph;
        int   exp_res;
        int   exp_sat;
    } win_vec_t;

    typedef struct {
        int res;
        int sat;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_drv, en_drv, rdy_drv, gate_drv, osc_drv, bypass;
    logic          w_gate;
    logic [CW-1:0] result;
    logic          result_valid, saturated, overrun;

    logic          s_valid, s_sat, s_ovr;
    logic [CW-1:0] s_result;
    int            v_cnt;
    int            n_checks = 0;
    int            n_fail   = 0;

    res_t          got_q[$];
    res_t          exp_q[$];
    win_vec_t      tbl[7];

    // Reference model: osc rises seen between consecutive gate rises, both ends inclusive.
    int            m_cnt;
    logic          m_armed, m_prev_g, m_prev_o;

    always #5 clk = ~clk;

    assign w_gate = bypass ? clk : gate_drv;

    ring_osc_freq_counter #(.CNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
        .clk_in       (clk),
        .rst          (rst_drv),
        .enable       (en_drv),
        .osc_in       (osc_drv),
        .gate_in      (w_gate),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (rdy_drv),
        .saturated    (saturated),
        .overrun      (overrun)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_step(input logic g, input logic o);
        logic gr, orr;
        if (rst_drv) begin
            m_armed = 1'b0; m_cnt = 0; m_prev_g = 1'b0; m_prev_o = 1'b0;
        end else begin
            gr = g & ~m_prev_g;
            orr = o & ~m_prev_o;
            m_prev_g = g;
            m_prev_o = o;
            if (!en_drv) begin
                m_armed = 1'b0; m_cnt = 0;
            end else if (gr) begin
                if (m_armed) begin
                    res_t e;
                    e.res = (m_cnt + int'(orr) > CMAX) ? CMAX : m_cnt + int'(orr);
                    e.sat = (m_cnt + int'(orr) > CMAX) ? 1 : 0;
                    exp_q.push_back(e);
                end
                m_armed = 1'b1;
                m_cnt = int'(orr);
            end else begin
                m_cnt += int'(orr);
            end
        end
    endtask

    // One clock: drive inputs, sample outputs on the falling edge, return just after the rising edge.
    task automatic cyc(input logic g, input logic o);
        res_t r;
        gate_drv = g;
        osc_drv  = o;
        model_step(g, o);
        @(negedge clk);
        s_valid  = result_valid;
        s_result = result;
        s_sat    = saturated;
        s_ovr    = overrun;
        if (s_valid) v_cnt++;
        if (s_valid && rdy_drv) begin
            r.res = int'(s_result);
            r.sat = int'(s_sat);
            got_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input int high, input int op, input int ph, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            int m;
            m = (k + op * 1000 - ph) % op;
            cyc(logic'(k < high), logic'(m < op / 2));
        end
    endtask

    task automatic run_window(input int len, input int high, input int op, input int ph);
        run_seg(high, op, ph, 0, len);
    endtask

    initial begin
        tbl[0] = '{2000, 1000, 20, 10, 100, 0};
        tbl[1] = '{2000, 1000, 20, 10, 100, 0};
        tbl[2] = '{1800,  900,  6,  3, 255, 1};
        tbl[3] = '{2000, 1000, 40, 20,  50, 0};
        tbl[4] = '{1000,  500, 10,  5, 100, 0};
        tbl[5] = '{1500,  700,  7,  3, 214, 0};
        tbl[6] = '{2000, 1000, 20, 10, 100, 0};

        rst_drv = 1'b1; en_drv = 1'b1; rdy_drv = 1'b1;
        gate_drv = 1'b0; osc_drv = 1'b0; bypass = 1'b0; v_cnt = 0;
        m_cnt = 0; m_armed = 1'b0; m_prev_g = 1'b0; m_prev_o = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b0, 1'b0);
        rst_drv = 1'b0;
        cyc(1'b0, 1'b0);
        chk("reset_result", int'(s_result), 0);
        chk("reset_valid",  int'(s_valid), 0);
        chk("reset_sat",    int'(s_sat), 0);
        chk("reset_ovr",    int'(s_ovr), 0);
        repeat (10) cyc(1'b0, 1'b0);

        // Directed windows: result of window i is delivered early in window i+1.
        got_q.delete();
        for (int i = 0; i < 7; i++) begin
            run_window(tbl[i].len, tbl[i].high, tbl[i].op, tbl[i].ph);
            chk($sformatf("tbl_count_%0d", i), got_q.size(), i);
            if (i >= 1 && got_q.size() >= i) begin
                chk($sformatf("tbl_result_%0d", i - 1), got_q[i-1].res, tbl[i-1].exp_res);
                chk($sformatf("tbl_sat_%0d", i - 1), got_q[i-1].sat, tbl[i-1].exp_sat);
            end
        end
        run_window(200, 100, 20, 10);
        chk("tbl_count_close", got_q.size(), 7);
        if (got_q.size() >= 7) begin
            chk("tbl_result_6", got_q[6].res, tbl[6].exp_res);
            chk("tbl_sat_6", got_q[6].sat, tbl[6].exp_sat);
        end
        chk("tbl_ovr", int'(s_ovr), 0);
        run_seg(0, 20, 10, 0, 20);

        // Latency: gate first sampled high at the next edge, valid three edges after it.
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0);
            chk($sformatf("latency_valid_%0d", k), int'(s_valid), (k == 4) ? 1 : 0);
        end
        chk("latency_result", int'(s_result), 11);
        repeat (20) cyc(1'b1, 1'b0);
        repeat (50) cyc(1'b0, 1'b0);

        // Overrun: two results while ready is low.
        run_window(2000, 1000, 20, 10);
        rdy_drv = 1'b0;
        run_window(2020, 1000, 20, 10);
        chk("ovr_first_valid",  int'(s_valid), 1);
        chk("ovr_first_result", int'(s_result), 100);
        chk("ovr_first_ovr",    int'(s_ovr), 0);
        run_seg(1000, 20, 10, 0, 20);
        chk("ovr_second_valid",  int'(s_valid), 1);
        chk("ovr_second_result", int'(s_result), 101);
        chk("ovr_second_ovr",    int'(s_ovr), 1);
        rdy_drv = 1'b1;
        run_seg(1000, 20, 10, 20, 21);
        rdy_drv = 1'b0;
        run_seg(1000, 20, 10, 21, 22);
        chk("ovr_take_valid", int'(s_valid), 0);
        chk("ovr_take_ovr",   int'(s_ovr), 0);
        run_seg(1000, 20, 10, 22, 2000);
        run_window(2000, 1000, 40, 20);

        // Transfer in the same cycle a new result loads.
        run_seg(1000, 20, 10, 0, 3);
        rdy_drv = 1'b1;
        run_seg(1000, 20, 10, 3, 4);
        chk("simul_pre_valid",  int'(s_valid), 1);
        chk("simul_pre_result", int'(s_result), 100);
        rdy_drv = 1'b0;
        run_seg(1000, 20, 10, 4, 5);
        chk("simul_valid",  int'(s_valid), 1);
        chk("simul_result", int'(s_result), 50);
        chk("simul_ovr",    int'(s_ovr), 0);
        rdy_drv = 1'b1;
        run_seg(1000, 20, 10, 5, 2000);

        // Reset 40 cycles into a window.
        run_seg(20, 20, 10, 0, 40);
        rst_drv = 1'b1;
        run_seg(20, 20, 10, 40, 41);
        rst_drv = 1'b0;
        rdy_drv = 1'b0;
        run_seg(20, 20, 10, 41, 42);
        chk("rst_result", int'(s_result), 0);
        chk("rst_valid",  int'(s_valid), 0);
        chk("rst_sat",    int'(s_sat), 0);
        chk("rst_ovr",    int'(s_ovr), 0);
        run_seg(20, 20, 10, 42, 2000);
        run_seg(1000, 20, 10, 0, 11);
        chk("rst_arm_only", int'(s_valid), 0);
        run_seg(1000, 20, 10, 11, 2000);
        run_seg(20, 20, 10, 0, 11);
        chk("rst_first_valid",  int'(s_valid), 1);
        chk("rst_first_result", int'(s_result), 100);

        // Enable dropped for 10 cycles mid-window.
        run_seg(20, 20, 10, 11, 40);
        en_drv = 1'b0;
        run_seg(20, 20, 10, 40, 50);
        en_drv = 1'b1;
        run_seg(20, 20, 10, 50, 51);
        chk("en_hold_valid",  int'(s_valid), 1);
        chk("en_hold_result", int'(s_result), 100);
        run_seg(20, 20, 10, 51, 2000);
        run_seg(1000, 40, 20, 0, 11);
        chk("en_rearm_valid",  int'(s_valid), 1);
        chk("en_rearm_result", int'(s_result), 100);
        chk("en_rearm_ovr",    int'(s_ovr), 0);
        rdy_drv = 1'b1;
        run_seg(1000, 40, 20, 11, 12);
        rdy_drv = 1'b0;
        run_seg(1000, 40, 20, 12, 13);
        chk("en_take_valid", int'(s_valid), 0);
        run_seg(1000, 40, 20, 13, 2000);
        run_seg(1000, 20, 10, 0, 10);
        chk("en_next_valid",  int'(s_valid), 1);
        chk("en_next_result", int'(s_result), 50);
        chk("en_next_ovr",    int'(s_ovr), 0);

        // Bypass: gate follows the system clock, no result may appear.
        rdy_drv = 1'b1;
        repeat (20) cyc(1'b1, 1'b0);
        v_cnt = 0;
        bypass = 1'b1;
        for (int i = 0; i < 5000; i++) cyc(1'b1, logic'((i % 10) < 5));
        chk("bypass_valid_cycles", v_cnt, 0);
        bypass = 1'b0;

        // Randomized windows against the model, consumer always ready.
        rst_drv = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        rst_drv = 1'b0;
        got_q.delete();
        exp_q.delete();
        repeat (5) cyc(1'b0, 1'b0);
        for (int w = 0; w < 10; w++) begin
            int len, high, op, ph;
            len  = int'($urandom_range(1200, 200));
            high = int'($urandom_range(len - 1, 1));
            op   = int'($urandom_range(40, 5));
            ph   = int'($urandom_range(op - 1, 0));
            run_window(len, high, op, ph);
        end
        run_window(60, 30, 20, 10);
        repeat (10) cyc(1'b0, 1'b0);
        chk("rand_count", got_q.size(), exp_q.size());
        chk("rand_model_count", exp_q.size(), 10);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("rand_result_%0d", i), got_q[i].res, exp_q[i].res);
            chk($sformatf("rand_sat_%0d", i), got_q[i].sat, exp_q[i].sat);
        end
        chk("rand_ovr", int'(s_ovr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_osc_freq_counter.md
Name: ring_osc_freq_counter

Overview:
- Gated frequency counter downstream of the clock divider in the temperature-sensor path.
- Counts rising edges of the ring-oscillator output (osc_in) over one full period of the divided gate clock (gate_in).
- Publishes each count as a temperature-proportional result through a valid/ready handshake toward the readout/serializer stage.
- osc_in is asynchronous to clk_in. gate_in is treated as asynchronous, since the divider may bypass and pass clk_in through unchanged.

Parameters:
- CNT_WIDTH, 24, width of the edge counter and of the result.
- SYNC_STAGES, 2, synchronizer flops on each of osc_in and gate_in; minimum 2.

Ports:
- clk_in  input  1  system clock; the only clock in the block
- rst  input  1  reset, synchronous, active-high
- enable  input  1  measurement enable; low = idle, counter and arm state cleared
- osc_in  input  1  ring-oscillator output, asynchronous
- gate_in  input  1  divided gate clock from the clock divider, asynchronous
- result  output  CNT_WIDTH  edge count of the last completed gate period
- result_valid  output  1  result holds an untaken measurement
- result_ready  input  1  consumer accepts result when high together with result_valid
- saturated  output  1  result clipped at all-ones
- overrun  output  1  at least one measurement was overwritten before it was taken

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is synchronous and active-high, sampled on the rising edge of clk_in.
- Reset values:
  - result=0, result_valid=0, saturated=0, overrun=0.
  - Internal counter=0, armed=0, synchronizer flops=0.
- Rst asserted mid-window discards the partial count. The first gate edge after reset only arms the block.
- Synchronization:
  - osc_in and gate_in each pass through SYNC_STAGES flops, then one registered "previous" flop.
  - Rising-edge pulse = sync AND NOT prev, one clk_in cycle wide.
  - osc edges closer than about 2 clk_in cycles are lost; the sensor design guarantees f_osc < f_clk_in/4.
- States: IDLE, ARMING, COUNTING.
  - IDLE: entered when enable=0. Counter held at 0, armed=0.
  - IDLE -> ARMING when enable=1.
  - ARMING -> COUNTING on the first gate rise. The partial window is discarded, counter := 0 (or 1 if an osc rise occurs in the same cycle).
  - COUNTING, each cycle:
    - osc rise: counter += 1, saturating at all-ones. A sticky window-saturation bit is set when increment is attempted at all-ones.
    - gate rise: result := counter (plus 1 if an osc rise occurs in the same cycle, still saturating). saturated := window bit. result_valid := 1. counter restarts exactly as on entry to COUNTING. Window bit cleared.
  - enable dropped in any state -> IDLE next cycle. result, result_valid, saturated and overrun are retained.
- Latency: result_valid rises SYNC_STAGES+1 clk_in edges after the first edge that samples gate_in high.
- Handshake:
  - Transfer occurs on any cycle where result_valid=1 and result_ready=1. result_valid falls next cycle unless a new result loads in that same cycle.
  - result is stable while result_valid=1 and no new gate rise occurs.
  - New result while valid=1 and ready=0: overwrite result and set overrun=1.
  - New result on the same cycle as a transfer: valid stays 1, overrun unchanged.
  - overrun is sticky and clears only on a transfer cycle with no simultaneous overwrite, or on rst.
- Bypass case: if gate_in is a copy of clk_in, the synchronizers see a constant level. No gate rise is detected and no results are produced. This is the required behaviour, not an error.
- Width rules: all arithmetic is unsigned CNT_WIDTH. No wrap-around; counting saturates.

Decomposition:
- Shared package freq_meas_pkg holds:
  - the state enum (IDLE/ARMING/COUNTING);
  - default CNT_WIDTH;
  - SYNC_STAGES minimum constant.
- One sub-module, sync_rise_detect (parameter SYNC_STAGES; ports clk_in, rst, async_in, level_out, rise_pulse), instantiated twice, for osc_in and gate_in.

Test Plan:
- Basic count:
  - Stimulus: enable=1, gate period 2000 clk_in (1000 high), osc rising every 20 clk_in, ready=1.
  - Required: first gate rise produces no result. Each subsequent window gives result=100 (exactly, when osc phase is fixed), one valid pulse per window, saturated=0, overrun=0.
- Latency:
  - Stimulus: gate_in driven high at a known edge.
  - Required: result_valid rises exactly SYNC_STAGES+1 = 3 edges later.
- Saturation:
  - Stimulus: CNT_WIDTH=8, 300 osc rises in one window.
  - Required: result=255, saturated=1. Next window with 50 rises gives result=50, saturated=0.
- Overrun and simultaneous events:
  - Stimulus: ready=0 across two windows (counts 100 then 101).
  - Required: result=101, overrun=1. Pulse ready for one cycle -> valid=0 and overrun=0 next cycle.
  - Repeat with ready=1 coinciding with the new-result cycle -> valid stays 1, overrun stays 0.
- Mid-window control:
  - Stimulus: assert rst at 40 edges into a window.
  - Required: all outputs 0 next cycle; the next gate rise only arms; the first result arrives one full window later.
  - Stimulus: repeat with enable=0 for 10 cycles.
  - Required: previous result/valid retained, re-arm required.
- Bypass:
  - Stimulus: gate_in tied to clk_in for 5000 cycles with osc toggling.
  - Required: result_valid never asserts.
